uart_core: RTL and testbench
============================

# uart_core

Parametrised full-duplex UART for the development-board link to the host game client. It replaces the fixed 8N1 transmitter/receiver pair with configurable data width, parity, stop bits and oversampling. It adds a valid/ready transmit handshake, a buffered receive path with per-word error flags, and overrun reporting. It sits between the board-side command logic and the rx/tx pins and runs on the 16×-baud UART clock domain.

## Interface
- OVERSAMPLE, 16: clock cycles per bit; even, ≥4.
- DATA_BITS, 8: payload width, 5..9, sent LSB first.
- PARITY, 0: 0 none, 1 odd, 2 even.
- STOP_BITS, 1: 1 or 2.
- RX_DEPTH, 4: RX FIFO entries; power of 2, ≥2.
- clock  in  1  UART clock (OVERSAMPLE × baud).
- reset  in  1  asynchronous, active-low reset.
- rx  in  1  serial input; asynchronous to clock.
- tx  out  1  serial output; idle high.
- tx_valid  in  1  tx_data is offered.
- tx_data  in  DATA_BITS  word to send.
- tx_ready  out  1  transmitter can accept a word this cycle.
- tx_busy  out  1  a frame is in progress.
- rx_valid  out  1  FIFO head is valid (show-ahead).
- rx_data  out  DATA_BITS  FIFO head payload.
- rx_perr  out  1  parity error flag of the head word.
- rx_ferr  out  1  framing error flag of the head word.
- rx_ready  in  1  pop the head word.
- overrun  out  1  one-cycle pulse when a received word is dropped because the FIFO is full.

## Operation
- Reset (reset low): tx=1, tx_ready=0, tx_busy=0, rx_valid=0, overrun=0, rx_perr=0, rx_ferr=0, FIFO empty, both FSMs IDLE, synchroniser flops =1.
  - tx_ready rises in the first cycle after reset release.
  - A mid-frame reset aborts the frame immediately; tx returns high.
- TX FSM: IDLE → START → DATA → PARITY (skipped when PARITY=0) → STOP → IDLE.
  - tx_ready = IDLE and out of reset.
  - Accept when tx_valid & tx_ready; data is latched at acceptance.
  - Each bit is held exactly OVERSAMPLE cycles; the bit counter restarts on acceptance, with no free-running divider.
  - Parity bit: odd mode makes the ones count in data+parity odd; even mode makes it even.
  - tx_busy = not IDLE.
- RX path: rx passes through a 2-flop synchroniser. RX FSM: IDLE → START → DATA → PARITY → STOP → (IDLE | WAIT_HIGH).
  - IDLE: a synchronised low moves to START and loads the counter.
  - START: sample at OVERSAMPLE/2 cycles. If high, treat as a false start and return to IDLE. If low, proceed.
  - Every later sample point is OVERSAMPLE cycles after the previous one.
  - Only the first stop bit is sampled; the second is not checked.
  - At the stop sample, the word is written as {ferr, perr, data}. ferr = stop sampled low. perr = parity mismatch; perr is always 0 when PARITY=0.
  - Next state is IDLE when the stop bit is high. When it is low, go to WAIT_HIGH and stay there until the synchronised rx is high (break handling).
- RX FIFO:
  - Push at the stop sample. If the FIFO is full at the start of that cycle, the word is dropped and overrun pulses, even if a pop happens in the same cycle.
  - Pop when rx_valid & rx_ready.
  - Push and pop together on a non-full FIFO both take effect; the count is unchanged.
  - Pointers wrap modulo RX_DEPTH and carry one extra bit for full/empty detection.

## Timing
- Frame length N = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS bits.
- TX: accept at cycle t, tx falls at t+1, and the last stop bit ends at t+N·OVERSAMPLE. tx_ready is 1 again at cycle t+1+N·OVERSAMPLE.
  - Back-to-back frames therefore have exactly one idle-high cycle between them.
- RX: the synchroniser adds 2 cycles. A word pushed at the stop-sample edge gives rx_valid=1 on the next cycle.
  - The receiver returns to IDLE at mid-stop-bit, so a following start bit is never missed.
- overrun is a single cycle, coincident with the rejected push.

## Structure
- Package uart_pkg holds:
  - Parity constants PARITY_NONE=0, PARITY_ODD=1, PARITY_EVEN=2.
  - The TX and RX state enums.
  - Parameter-legality checks (elaboration error on illegal values).
- Sub-module uart_rx_fifo: synchronous show-ahead FIFO, width DATA_BITS+2, depth RX_DEPTH, same clock and reset.
- The TX FSM, RX FSM and synchroniser live in uart_core.

## Test plan
- 16/8/even/1, send 0xA5 → tx = 0, 1,0,1,0,0,1,0,1, parity 0, 1. Each bit lasts 16 cycles, and tx_ready returns 177 cycles after acceptance.
- Loopback tx→rx, 8N1, bytes 0x00, 0xFF, 0x3C back-to-back → the same three bytes pop in order with perr=ferr=0.
- Drive a frame with a flipped parity bit (odd mode) → the word is delivered with rx_perr=1. Drive a stop bit of 0 → rx_ferr=1, and the FSM holds in WAIT_HIGH until rx goes high.
- RX_DEPTH=4, rx_ready=0, receive 5 bytes → 4 are stored, overrun pulses once on the 5th, and pops return the first 4.
- A 3-cycle low glitch on idle rx → no word is pushed and the FSM is back in IDLE.
- Assert reset during a TX data bit and during an RX data bit → tx=1 immediately, the FIFO is empty, and the next full frame after release transmits and receives correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants, FSM state encodings and parameter legality check for the UART.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    function automatic bit params_legal(int os, int db, int par, int sb, int depth);
        return (os >= 4) && (os % 2 == 0) && (db >= 5) && (db <= 9) &&
               (par >= PARITY_NONE) && (par <= PARITY_EVEN) &&
               (sb == 1 || sb == 2) && (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO; pointers carry one extra bit to tell full from empty.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] dout
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign valid = (wr_ptr != rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // Head is forced to zero when empty so the error flags read 0 out of reset.
    assign dout  = valid ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && valid)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: bit-timed transmitter, oversampling receiver with a
// 2-flop synchroniser, and a buffered receive path with per-word error flags.
module uart_core
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int RX_DEPTH   = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx,
    output logic                 tx,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_perr,
    output logic                 rx_ferr,
    input  logic                 rx_ready,
    output logic                 overrun,
    output logic [2:0]           tx_state_dbg,
    output logic [2:0]           rx_state_dbg
);
    if (!params_legal(OVERSAMPLE, DATA_BITS, PARITY, STOP_BITS, RX_DEPTH)) begin : g_illegal_params
        $error("uart_core: illegal parameter combination");
    end

    localparam int             CW         = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0]  BIT_LAST   = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0]  HALF_LAST  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]     DATA_LAST  = 4'(DATA_BITS - 1);
    localparam bit             HAS_PARITY = (PARITY != PARITY_NONE);

    // Handshakes: a tx word transfers on a clock where tx_valid && tx_ready;
    // an rx word is consumed on a clock where rx_valid && rx_ready.
    tx_state_t            tx_state;
    logic [CW-1:0]        tx_cnt;
    logic [3:0]           tx_idx;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;
    logic                 tx_stop_idx;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_state    <= TX_IDLE;
            tx          <= 1'b1;
            tx_ready    <= 1'b0;
            tx_busy     <= 1'b0;
            tx_cnt      <= '0;
            tx_idx      <= '0;
            tx_shift    <= '0;
            tx_par      <= 1'b0;
            tx_stop_idx <= 1'b0;
        end else if (tx_state == TX_IDLE) begin
            tx       <= 1'b1;
            tx_ready <= 1'b1;
            if (tx_valid && tx_ready) begin
                tx_state <= TX_START;
                tx       <= 1'b0;
                tx_ready <= 1'b0;
                tx_busy  <= 1'b1;
                tx_cnt   <= '0;
                tx_shift <= tx_data;
                tx_par   <= (PARITY == PARITY_ODD) ? ~^tx_data : ^tx_data;
            end
        end else if (tx_cnt != BIT_LAST) begin
            tx_cnt <= tx_cnt + CW'(1);
        end else begin
            tx_cnt <= '0;
            case (tx_state)
                TX_START: begin
                    tx_state <= TX_DATA;
                    tx       <= tx_shift[0];
                    tx_idx   <= '0;
                end
                TX_DATA: begin
                    if (tx_idx != DATA_LAST) begin
                        tx_idx   <= tx_idx + 4'd1;
                        tx_shift <= tx_shift >> 1;
                        tx       <= tx_shift[1];
                    end else if (HAS_PARITY) begin
                        tx_state <= TX_PARITY;
                        tx       <= tx_par;
                    end else begin
                        tx_state    <= TX_STOP;
                        tx          <= 1'b1;
                        tx_stop_idx <= 1'b0;
                    end
                end
                TX_PARITY: begin
                    tx_state    <= TX_STOP;
                    tx          <= 1'b1;
                    tx_stop_idx <= 1'b0;
                end
                TX_STOP: begin
                    if (tx_stop_idx == 1'(STOP_BITS - 1)) begin
                        tx_state <= TX_IDLE;
                        tx_ready <= 1'b1;
                        tx_busy  <= 1'b0;
                    end else begin
                        tx_stop_idx <= 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    logic [1:0]           rx_sync;
    logic                 rx_s;
    rx_state_t            rx_state;
    logic [CW-1:0]        rx_cnt;
    logic [3:0]           rx_idx;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par_bit;
    logic                 rx_sample;
    logic                 push;
    logic                 perr_calc;
    logic                 fifo_full;

    assign rx_s      = rx_sync[1];
    assign rx_sample = (rx_cnt == BIT_LAST);
    assign push      = (rx_state == RX_STOP) && rx_sample;
    assign perr_calc = HAS_PARITY && ((^rx_shift ^ rx_par_bit) != (PARITY == PARITY_ODD));
    assign overrun   = push && fifo_full;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_sync    <= 2'b11;
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_idx     <= '0;
            rx_shift   <= '0;
            rx_par_bit <= 1'b0;
        end else begin
            rx_sync <= {rx_sync[0], rx};
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_idx   <= '0;
                        rx_state <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                RX_DATA, RX_PARITY, RX_STOP: begin
                    rx_cnt <= rx_sample ? '0 : rx_cnt + CW'(1);
                    if (rx_sample) begin
                        if (rx_state == RX_DATA) begin
                            rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
                            rx_idx   <= rx_idx + 4'd1;
                            if (rx_idx == DATA_LAST)
                                rx_state <= HAS_PARITY ? RX_PARITY : RX_STOP;
                        end else if (rx_state == RX_PARITY) begin
                            rx_par_bit <= rx_s;
                            rx_state   <= RX_STOP;
                        end else begin
                            // A low stop bit may be a break; wait for the line to recover.
                            rx_state <= rx_s ? RX_IDLE : RX_WAIT_HIGH;
                        end
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_s) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS + 2),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .din   ({!rx_s, perr_calc, rx_shift}),
        .full  (fifo_full),
        .pop   (rx_ready),
        .valid (rx_valid),
        .dout  ({rx_ferr, rx_perr, rx_data})
    );

    assign tx_state_dbg = tx_state;
    assign rx_state_dbg = rx_state;

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: three instances (even parity, no-parity loopback, odd parity).
module tb_uart_core;
    import uart_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    int         checks = 0;
    int         passes = 0;
    int         ov_cnt = 0;
    logic [9:0] exp_q[$];

    logic       a_rx, a_tx, a_tx_valid, a_tx_ready, a_tx_busy, a_rx_valid, a_rx_perr, a_rx_ferr, a_rx_ready, a_overrun;
    logic [7:0] a_tx_data, a_rx_data;
    logic [2:0] a_tx_st, a_rx_st;
    logic       b_tx, b_tx_valid, b_tx_ready, b_tx_busy, b_rx_valid, b_rx_perr, b_rx_ferr, b_rx_ready, b_overrun;
    logic [7:0] b_tx_data, b_rx_data;
    logic [2:0] b_tx_st, b_rx_st;
    logic       c_rx, c_tx, c_tx_valid, c_tx_ready, c_tx_busy, c_rx_valid, c_rx_perr, c_rx_ferr, c_rx_ready, c_overrun;
    logic [7:0] c_tx_data, c_rx_data;
    logic [2:0] c_tx_st, c_rx_st;

    uart_core #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY(PARITY_EVEN), .STOP_BITS(1), .RX_DEPTH(4)) u_a (
        .clock(clock), .reset(reset), .rx(a_rx), .tx(a_tx), .tx_valid(a_tx_valid), .tx_data(a_tx_data),
        .tx_ready(a_tx_ready), .tx_busy(a_tx_busy), .rx_valid(a_rx_valid), .rx_data(a_rx_data),
        .rx_perr(a_rx_perr), .rx_ferr(a_rx_ferr), .rx_ready(a_rx_ready), .overrun(a_overrun),
        .tx_state_dbg(a_tx_st), .rx_state_dbg(a_rx_st));

    uart_core #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY(PARITY_NONE), .STOP_BITS(1), .RX_DEPTH(4)) u_b (
        .clock(clock), .reset(reset), .rx(b_tx), .tx(b_tx), .tx_valid(b_tx_valid), .tx_data(b_tx_data),
        .tx_ready(b_tx_ready), .tx_busy(b_tx_busy), .rx_valid(b_rx_valid), .rx_data(b_rx_data),
        .rx_perr(b_rx_perr), .rx_ferr(b_rx_ferr), .rx_ready(b_rx_ready), .overrun(b_overrun),
        .tx_state_dbg(b_tx_st), .rx_state_dbg(b_rx_st));

    uart_core #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY(PARITY_ODD), .STOP_BITS(1), .RX_DEPTH(4)) u_c (
        .clock(clock), .reset(reset), .rx(c_rx), .tx(c_tx), .tx_valid(c_tx_valid), .tx_data(c_tx_data),
        .tx_ready(c_tx_ready), .tx_busy(c_tx_busy), .rx_valid(c_rx_valid), .rx_data(c_rx_data),
        .rx_perr(c_rx_perr), .rx_ferr(c_rx_ferr), .rx_ready(c_rx_ready), .overrun(c_overrun),
        .tx_state_dbg(c_tx_st), .rx_state_dbg(c_rx_st));

    // Frame vectors are LSB first: bit 0 is the start bit, bit 10 the stop bit.
    task automatic drive_rx(input int which, input logic [10:0] bits);
        for (int i = 0; i < 11; i++) begin
            if (which == 0) a_rx = bits[i];
            else            c_rx = bits[i];
            repeat (16) begin
                @(negedge clock);
                if (a_overrun) ov_cnt++;
            end
        end
    endtask

    task automatic pulse_ready(input int which);
        if (which == 0) a_rx_ready = 1'b1;
        else if (which == 1) b_rx_ready = 1'b1;
        else c_rx_ready = 1'b1;
        @(negedge clock);
        a_rx_ready = 1'b0;
        b_rx_ready = 1'b0;
        c_rx_ready = 1'b0;
    endtask

    task automatic tx_check_frame(input logic [7:0] d, input logic [10:0] exp_bits);
        logic exp_tx;
        checks++;
        if (a_tx_ready !== 1'b1) $display("FAIL tx_ready_before_send got %b want 1", a_tx_ready);
        else passes++;
        a_tx_valid = 1'b1;
        a_tx_data  = d;
        @(negedge clock);
        a_tx_valid = 1'b0;
        for (int c = 0; c <= 176; c++) begin
            if (c > 0) @(negedge clock);
            exp_tx = (c < 176) ? exp_bits[c / 16] : 1'b1;
            checks++;
            if (a_tx !== exp_tx) $display("FAIL tx_line cycle %0d got %b want %b", c, a_tx, exp_tx);
            else passes++;
            if (c == 0 || c == 176) begin
                checks++;
                if (a_tx_busy !== (c == 0)) $display("FAIL tx_busy cycle %0d got %b want %b", c, a_tx_busy, c == 0);
                else passes++;
            end
            if (c == 175 || c == 176) begin
                checks++;
                if (a_tx_ready !== (c == 176)) $display("FAIL tx_ready cycle %0d got %b want %b", c, a_tx_ready, c == 176);
                else passes++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (a_tx !== 1'b1) $display("FAIL reset_tx got %b want 1", a_tx); else passes++;
        checks++; if (b_tx !== 1'b1) $display("FAIL reset_b_tx got %b want 1", b_tx); else passes++;
        checks++; if (a_tx_ready !== 1'b0) $display("FAIL reset_tx_ready got %b want 0", a_tx_ready); else passes++;
        checks++; if (a_tx_busy !== 1'b0) $display("FAIL reset_tx_busy got %b want 0", a_tx_busy); else passes++;
        checks++; if (a_rx_valid !== 1'b0) $display("FAIL reset_rx_valid got %b want 0", a_rx_valid); else passes++;
        checks++; if (a_overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", a_overrun); else passes++;
        checks++; if ({a_rx_ferr, a_rx_perr} !== 2'b00) $display("FAIL reset_flags got %b want 00", {a_rx_ferr, a_rx_perr}); else passes++;
        checks++; if ({a_tx_st, a_rx_st} !== 6'd0) $display("FAIL reset_states got %0d/%0d want 0/0", a_tx_st, a_rx_st); else passes++;
        reset = 1'b1;
        @(negedge clock);
        checks++; if (a_tx_ready !== 1'b1) $display("FAIL tx_ready_after_reset got %b want 1", a_tx_ready); else passes++;
    endtask

    task automatic test_tx_pattern();
        // 0xA5 has four ones, so the even parity bit is 0.
        tx_check_frame(8'hA5, {1'b1, 1'b0, 8'hA5, 1'b0});
    endtask

    task automatic test_loopback();
        logic [7:0] bytes [3];
        logic [9:0] e;
        int n;
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            b_tx_valid = 1'b1;
            b_tx_data  = bytes[i];
            exp_q.push_back({2'b00, bytes[i]});
            n = 0;
            while (!b_tx_ready && n < 500) begin
                @(negedge clock);
                n++;
            end
            checks++;
            if (n >= 500) $display("FAIL loop_handshake byte %0d got timeout want ready", i); else passes++;
            @(negedge clock);
        end
        b_tx_valid = 1'b0;
        repeat (200) @(negedge clock);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (b_rx_valid !== 1'b1 || {b_rx_ferr, b_rx_perr, b_rx_data} !== e)
                $display("FAIL loop_word got v=%b %h want v=1 %h", b_rx_valid, {b_rx_ferr, b_rx_perr, b_rx_data}, e);
            else passes++;
            pulse_ready(1);
        end
        checks++; if (b_rx_valid !== 1'b0) $display("FAIL loop_empty got %b want 0", b_rx_valid); else passes++;
    endtask

    task automatic test_parity_error();
        logic [9:0] e;
        // Odd mode: 0x07 (three ones) needs parity 0; 0x5A (four ones) needs 1 but gets 0.
        drive_rx(1, {1'b1, 1'b0, 8'h07, 1'b0});
        exp_q.push_back({2'b00, 8'h07});
        drive_rx(1, {1'b1, 1'b0, 8'h5A, 1'b0});
        exp_q.push_back({2'b01, 8'h5A});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (c_rx_valid !== 1'b1 || {c_rx_ferr, c_rx_perr, c_rx_data} !== e)
                $display("FAIL parity_word got v=%b %h want v=1 %h", c_rx_valid, {c_rx_ferr, c_rx_perr, c_rx_data}, e);
            else passes++;
            pulse_ready(2);
        end
        checks++; if (c_rx_valid !== 1'b0) $display("FAIL parity_empty got %b want 0", c_rx_valid); else passes++;
    endtask

    task automatic test_framing();
        drive_rx(0, {1'b0, 1'b0, 8'h3C, 1'b0});
        repeat (20) @(negedge clock);
        checks++; if (a_rx_st !== 3'd5) $display("FAIL ferr_wait_high state got %0d want 5", a_rx_st); else passes++;
        checks++;
        if (a_rx_valid !== 1'b1 || {a_rx_ferr, a_rx_perr, a_rx_data} !== {2'b10, 8'h3C})
            $display("FAIL ferr_word got v=%b %h want v=1 %h", a_rx_valid, {a_rx_ferr, a_rx_perr, a_rx_data}, {2'b10, 8'h3C});
        else passes++;
        a_rx = 1'b1;
        repeat (4) @(negedge clock);
        checks++; if (a_rx_st !== 3'd0) $display("FAIL ferr_recover state got %0d want 0", a_rx_st); else passes++;
        pulse_ready(0);
        checks++; if (a_rx_valid !== 1'b0) $display("FAIL ferr_empty got %b want 0", a_rx_valid); else passes++;
    endtask

    task automatic test_overrun();
        logic [7:0] bytes [5];
        logic       pars  [5];
        logic [9:0] e;
        bytes[0] = 8'h11; pars[0] = 1'b0;
        bytes[1] = 8'h23; pars[1] = 1'b1;
        bytes[2] = 8'h33; pars[2] = 1'b0;
        bytes[3] = 8'h07; pars[3] = 1'b1;
        bytes[4] = 8'h55; pars[4] = 1'b0;
        ov_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            drive_rx(0, {1'b1, pars[i], bytes[i], 1'b0});
            exp_q.push_back({2'b00, bytes[i]});
        end
        checks++; if (ov_cnt !== 0) $display("FAIL overrun_early got %0d want 0", ov_cnt); else passes++;
        drive_rx(0, {1'b1, pars[4], bytes[4], 1'b0});
        checks++; if (ov_cnt !== 1) $display("FAIL overrun_pulses got %0d want 1", ov_cnt); else passes++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (a_rx_valid !== 1'b1 || {a_rx_ferr, a_rx_perr, a_rx_data} !== e)
                $display("FAIL overrun_word got v=%b %h want v=1 %h", a_rx_valid, {a_rx_ferr, a_rx_perr, a_rx_data}, e);
            else passes++;
            pulse_ready(0);
        end
        checks++; if (a_rx_valid !== 1'b0) $display("FAIL overrun_empty got %b want 0", a_rx_valid); else passes++;
    endtask

    task automatic test_glitch();
        a_rx = 1'b0;
        repeat (3) @(negedge clock);
        a_rx = 1'b1;
        checks++; if (a_rx_st !== 3'd1) $display("FAIL glitch_start state got %0d want 1", a_rx_st); else passes++;
        repeat (20) @(negedge clock);
        checks++; if (a_rx_st !== 3'd0) $display("FAIL glitch_idle state got %0d want 0", a_rx_st); else passes++;
        checks++; if (a_rx_valid !== 1'b0) $display("FAIL glitch_no_push got %b want 0", a_rx_valid); else passes++;
    endtask

    task automatic test_reset_midframe();
        drive_rx(0, {1'b1, 1'b0, 8'h66, 1'b0});
        checks++; if (a_rx_valid !== 1'b1) $display("FAIL midrst_prefill got %b want 1", a_rx_valid); else passes++;
        a_tx_valid = 1'b1;
        a_tx_data  = 8'h00;
        @(negedge clock);
        a_tx_valid = 1'b0;
        a_rx = 1'b0;
        repeat (16) @(negedge clock);
        a_rx = 1'b1;
        repeat (24) @(negedge clock);
        checks++; if ({a_tx_st, a_rx_st} !== {3'd2, 3'd2}) $display("FAIL midrst_in_data got %0d/%0d want 2/2", a_tx_st, a_rx_st); else passes++;
        reset = 1'b0;
        #1;
        checks++; if (a_tx !== 1'b1) $display("FAIL midrst_tx got %b want 1", a_tx); else passes++;
        checks++; if (a_tx_busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", a_tx_busy); else passes++;
        checks++; if (a_rx_valid !== 1'b0) $display("FAIL midrst_fifo got %b want 0", a_rx_valid); else passes++;
        checks++; if ({a_tx_st, a_rx_st} !== 6'd0) $display("FAIL midrst_states got %0d/%0d want 0/0", a_tx_st, a_rx_st); else passes++;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        tx_check_frame(8'h81, {1'b1, 1'b0, 8'h81, 1'b0});
        drive_rx(0, {1'b1, 1'b0, 8'h81, 1'b0});
        checks++;
        if (a_rx_valid !== 1'b1 || {a_rx_ferr, a_rx_perr, a_rx_data} !== {2'b00, 8'h81})
            $display("FAIL midrst_rx_word got v=%b %h want v=1 %h", a_rx_valid, {a_rx_ferr, a_rx_perr, a_rx_data}, {2'b00, 8'h81});
        else passes++;
        pulse_ready(0);
        checks++; if (a_rx_valid !== 1'b0) $display("FAIL midrst_final_empty got %b want 0", a_rx_valid); else passes++;
    endtask

    initial begin
        reset = 1'b0;
        a_rx = 1'b1; c_rx = 1'b1;
        a_tx_valid = 1'b0; b_tx_valid = 1'b0; c_tx_valid = 1'b0;
        a_tx_data = 8'h00; b_tx_data = 8'h00; c_tx_data = 8'h00;
        a_rx_ready = 1'b0; b_rx_ready = 1'b0; c_rx_ready = 1'b0;
        @(negedge clock);
        test_reset();
        test_tx_pattern();
        test_loopback();
        test_parity_error();
        test_framing();
        test_overrun();
        test_glitch();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
